// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - handshake/operand/result bundle for the shift-add multiplier
//
// Purpose: groups the request side (start, operands) and the result side
// (busy, done, product) of seq_shift_add_multiplier.
// Ports (signals):
//   start         request pulse, driven by master
//   multiplicand  N-bit operand A, driven by master
//   multiplier    N-bit operand B, driven by master
//   busy          operation in progress, driven by slave
//   done          one-cycle product-valid strobe, driven by slave
//   product       2N-bit result register, driven by slave
// Modports: master (requester), slave (the multiplier).

interface seq_shift_add_multiplier_if #(
   parameter int N = 32
);
   logic             start;
   logic [N-1:0]     multiplicand;
   logic [N-1:0]     multiplier;
   logic             busy;
   logic             done;
   logic [2*N-1:0]   product;

   modport master (
      output start, multiplicand, multiplier,
      input  busy, done, product
   );

   modport slave (
      input  start, multiplicand, multiplier,
      output busy, done, product
   );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative N-cycle shift-and-add multiplier
//
// Purpose: accepts two N-bit operands on a start pulse, computes the exact
// 2N-bit product with one add/shift per clock, and writes it to the product
// register together with a one-cycle done strobe.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset, highest priority
//   bus    seq_shift_add_multiplier_if.slave (start, multiplicand, multiplier,
//          busy, done, product)
// Optional feature: define MULT_SIGNED_EN for two's complement operands
// (magnitudes are multiplied, the result is negated when the signs differ).

module seq_shift_add_multiplier #(
   parameter int N = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   seq_shift_add_multiplier_if.slave bus
);
   localparam int            CW   = (N > 2) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state;
   logic             busy_r;
   logic             done_r;
   logic [2*N-1:0]   product_r;
   logic [CW-1:0]    cnt;
   logic [N-1:0]     mcand_r;   // latched multiplicand (magnitude in signed mode)
   logic [N-1:0]     acc_hi;    // upper half of the running product
   logic [N-1:0]     mreg;      // multiplier shift register / lower product half

   logic [N-1:0]     op_a;
   logic [N-1:0]     op_b;
   logic [N:0]       sum;
   logic [2*N-1:0]   result;
   logic [2*N-1:0]   result_final;

   // N+1-bit add keeps the carry that the following right shift pulls down.
   assign sum    = {1'b0, acc_hi} + (mreg[0] ? {1'b0, mcand_r} : {(N+1){1'b0}});
   // {sum, mreg} shifted right by one, as it would be after this iteration.
   assign result = {sum, mreg[N-1:1]};

`ifdef MULT_SIGNED_EN
   logic sign_r;
   // Unary minus on N bits yields 2^(N-1) for the most-negative value,
   // which is the correct unsigned magnitude.
   assign op_a = bus.multiplicand[N-1] ? -bus.multiplicand : bus.multiplicand;
   assign op_b = bus.multiplier[N-1]   ? -bus.multiplier   : bus.multiplier;
   assign result_final = sign_r ? -result : result;
`else
   assign op_a = bus.multiplicand;
   assign op_b = bus.multiplier;
   assign result_final = result;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= '0;
         cnt       <= '0;
         mcand_r   <= '0;
         acc_hi    <= '0;
         mreg      <= '0;
`ifdef MULT_SIGNED_EN
         sign_r    <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  mcand_r <= op_a;
                  mreg    <= op_b;
                  acc_hi  <= '0;
                  cnt     <= '0;
`ifdef MULT_SIGNED_EN
                  sign_r  <= bus.multiplicand[N-1] ^ bus.multiplier[N-1];
`endif
                  busy_r  <= 1'b1;
                  state   <= CALC;
               end else begin
                  state   <= IDLE;
               end
            end
            CALC: begin
               acc_hi <= sum[N:1];
               mreg   <= {sum[0], mreg[N-1:1]};
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  product_r <= result_final;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.product = product_r;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb/tb_seq_shift_add_multiplier.sv - self-checking bench for seq_shift_add_multiplier (N=8)

module tb_seq_shift_add_multiplier;
   localparam int N = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;

   seq_shift_add_multiplier_if #(.N(N)) bus ();

   seq_shift_add_multiplier #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [2*N-1:0] sb_q[$];

   function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MULT_SIGNED_EN
      logic signed [2*N-1:0] sa, sb, p;
      sa = {{N{a[N-1]}}, a};
      sb = {{N{b[N-1]}}, b};
      p  = sa * sb;
      return p;
`else
      logic [2*N-1:0] p;
      p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      return p;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b);
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      sb_q.push_back(model(a, b));
      step();
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for done; counts cycles observed with busy high.
   task automatic wait_done(output int busy_cycles, output bit seen);
      busy_cycles = 0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy) busy_cycles++;
         step();
      end
   endtask

   task automatic finish_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b);
      int bc;
      bit seen;
      logic [2*N-1:0] exp_p;
      drive_start(a, b);
      wait_done(bc, seen);
      exp_p = sb_q.pop_front();
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_done_timeout: got no done, required done within 40 cycles", name);
      end
      checks++;
      if (bc !== N) begin
         errors++;
         $display("FAIL %s_busy_cycles: got %0d, required %0d", name, bc, N);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_busy_with_done: got %b, required 0", name, bus.busy);
      end
      checks++;
      if (bus.product !== exp_p) begin
         errors++;
         $display("FAIL %s_product: got %h, required %h", name, bus.product, exp_p);
      end
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.product !== exp_p) begin
         errors++;
         $display("FAIL %s_hold: got done=%b product=%h, required done=0 product=%h",
                  name, bus.done, bus.product, exp_p);
      end
   endtask

   task automatic test_reset();
      int dcount;
      reset = 1'b1;
      bus.start = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier = '0;
      step();
      step();
      reset = 1'b0;
      checks++;
      if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got product=%h busy=%b done=%b, required 0/0/0",
                  bus.product, bus.busy, bus.done);
      end
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.done || bus.busy) dcount++;
         step();
      end
      checks++;
      if (dcount !== 0) begin
         errors++;
         $display("FAIL idle_no_activity: got %0d active cycles, required 0", dcount);
      end
   endtask

   task automatic test_basic();
      finish_op("mul_13x11", 8'd13, 8'd11);
      for (int i = 0; i < 3; i++) step();
      checks++;
      if (bus.product !== model(8'd13, 8'd11)) begin
         errors++;
         $display("FAIL hold_143: got %h, required %h", bus.product, model(8'd13, 8'd11));
      end
   endtask

   task automatic test_edge_operands();
      finish_op("mul_ffxff", 8'hFF, 8'hFF);
      finish_op("mul_0xab", 8'h00, 8'hAB);
      finish_op("mul_80x80", 8'h80, 8'h80);
      for (int i = 0; i < 4; i++) finish_op("mul_rand", N'($urandom), N'($urandom));
   endtask

   task automatic test_ignore_mid_calc();
      int bc;
      bit seen;
      logic [2*N-1:0] exp_p;
      drive_start(8'd13, 8'd11);
      step();
      step();
      bus.start = 1'b1;
      bus.multiplicand = 8'd2;
      bus.multiplier = 8'd2;
      step();
      bus.start = 1'b0;
      bus.multiplicand = 8'd99;
      bus.multiplier = 8'd77;
      wait_done(bc, seen);
      exp_p = sb_q.pop_front();
      checks++;
      if (!seen || bus.product !== exp_p) begin
         errors++;
         $display("FAIL mid_calc_ignore: got seen=%b product=%h, required 1/%h", seen, bus.product, exp_p);
      end
      step();
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_calc_not_queued: got busy=%b, required 0", bus.busy);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      bit seen;
      logic [2*N-1:0] exp_p;
      drive_start(8'd13, 8'd11);
      wait_done(bc, seen);
      exp_p = sb_q.pop_front();
      checks++;
      if (!seen || bus.product !== exp_p) begin
         errors++;
         $display("FAIL b2b_first: got seen=%b product=%h, required 1/%h", seen, bus.product, exp_p);
      end
      drive_start(8'd3, 8'd5);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: got busy=%b done=%b, required 1/0", bus.busy, bus.done);
      end
      wait_done(bc, seen);
      exp_p = sb_q.pop_front();
      checks++;
      if (!seen || bc !== N || bus.product !== exp_p) begin
         errors++;
         $display("FAIL b2b_second: got seen=%b busy_cycles=%0d product=%h, required 1/%0d/%h",
                  seen, bc, bus.product, N, exp_p);
      end
      step();
   endtask

   task automatic test_reset_mid_calc();
      int dcount;
      drive_start(8'd13, 8'd11);
      for (int i = 0; i < 3; i++) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      void'(sb_q.pop_front());
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
         errors++;
         $display("FAIL reset_mid_calc: got busy=%b done=%b product=%h, required 0/0/0",
                  bus.busy, bus.done, bus.product);
      end
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         if (bus.done || bus.busy) dcount++;
         step();
      end
      checks++;
      if (dcount !== 0) begin
         errors++;
         $display("FAIL reset_discard: got %0d active cycles, required 0", dcount);
      end
      finish_op("after_reset_7x9", 8'd7, 8'd9);
   endtask

`ifdef MULT_SIGNED_EN
   task automatic test_signed();
      finish_op("s_m3x7", 8'hFD, 8'd7);
      checks++;
      if (bus.product !== 16'hFFEB) begin
         errors++;
         $display("FAIL s_m3x7_const: got %h, required FFEB", bus.product);
      end
      finish_op("s_m128xm128", 8'h80, 8'h80);
      checks++;
      if (bus.product !== 16'h4000) begin
         errors++;
         $display("FAIL s_m128xm128_const: got %h, required 4000", bus.product);
      end
      finish_op("s_m128x1", 8'h80, 8'h01);
      checks++;
      if (bus.product !== 16'hFF80) begin
         errors++;
         $display("FAIL s_m128x1_const: got %h, required FF80", bus.product);
      end
   endtask
`endif

   initial begin
      bus.start = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier = '0;
      test_reset();
      test_basic();
      test_edge_operands();
      test_ignore_mid_calc();
      test_back_to_back();
      test_reset_mid_calc();
`ifdef MULT_SIGNED_EN
      test_signed();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
